// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I load/store unit: FSM states,
// funct3 size codes, byte-mask constants and the funct3 legality check.
package rv32i_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B0   = 4'b0001;
  localparam logic [3:0] MASK_LO   = 4'b0011;
  localparam logic [3:0] MASK_HI   = 4'b1100;
  localparam logic [3:0] MASK_ALL  = 4'b1111;

  // Stores only have signed-size encodings; the unsigned ones are load-only.
  function automatic logic f3_supported(input logic [2:0] f3, input logic we);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv32i_lsu_if.sv
// Data-memory request/ready port between the load/store unit and memory.
interface rv32i_lsu_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W/8-1:0]   mem_wmask_o;
  logic                  mem_ready_i;
  logic [DATA_W-1:0]     mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/rv32i_lsu_align.sv
// Combinational byte-lane logic: store replication/write mask and
// load extraction with sign/zero extension.
module rv32i_lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  st_f3,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata_c,
  output logic [3:0]  st_mask_c,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data_c
);

  logic [1:0]  ld_shift;
  logic [31:0] ld_sh;

  // Store path: replicate the datum across lanes and enable only its bytes.
  always_comb begin
    st_wdata_c = st_data;
    st_mask_c  = MASK_NONE;
    case (st_f3)
      F3_B: begin
        st_wdata_c = {4{st_data[7:0]}};
        st_mask_c  = MASK_B0 << st_lane;
      end
      F3_H: begin
        st_wdata_c = {2{st_data[15:0]}};
        st_mask_c  = st_lane[1] ? MASK_HI : MASK_LO;
      end
      F3_W:    st_mask_c = MASK_ALL;
      default: st_mask_c = MASK_NONE;
    endcase
  end

  // Load path: halfwords ignore addr[0], words ignore both low bits.
  always_comb begin
    ld_shift  = 2'b00;
    ld_data_c = '0;
    case (ld_f3)
      F3_B, F3_BU: ld_shift = ld_lane;
      F3_H, F3_HU: ld_shift = {ld_lane[1], 1'b0};
      default:     ld_shift = 2'b00;
    endcase
    ld_sh = ld_rdata >> {ld_shift, 3'b000};
    case (ld_f3)
      F3_B:    ld_data_c = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_BU:   ld_data_c = {24'h0, ld_sh[7:0]};
      F3_H:    ld_data_c = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_HU:   ld_data_c = {16'h0, ld_sh[15:0]};
      F3_W:    ld_data_c = ld_rdata;
      default: ld_data_c = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I multi-cycle load/store unit (IDLE -> REQ -> DONE).
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses via misaligned_o.
module rv32i_lsu
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              access_err_o,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misaligned_o,
`endif
  rv32i_lsu_if.master       mem
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic              err_q, err_d;
  logic [31:0]       st_wdata_c, ld_data_c;
  logic [3:0]        st_mask_c;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic misalign_c;

  assign misalign_c = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
  assign misaligned_o = mis_q;
`endif

  rv32i_lsu_align u_align (
    .st_f3      (funct3_i),
    .st_lane    (addr_i[1:0]),
    .st_data    (store_data_i),
    .st_wdata_c (st_wdata_c),
    .st_mask_c  (st_mask_c),
    .ld_f3      (f3_q),
    .ld_lane    (addr_q[1:0]),
    .ld_rdata   (mem.mem_rdata_i),
    .ld_data_c  (ld_data_c)
  );

  // Next-state and datapath capture; stall_o is the only combinational output.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    ld_d    = ld_q;
    err_d   = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && (is_load_i || is_store_i)) begin
          stall_o = 1'b1;
          addr_d  = addr_i;
          f3_d    = funct3_i;
          we_d    = is_store_i;
          wdata_d = st_wdata_c;
          wmask_d = is_store_i ? st_mask_c : MASK_NONE;
          if (!f3_supported(funct3_i, is_store_i)) begin
            err_d   = 1'b1;
            ld_d    = '0;
            state_d = S_DONE;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (misalign_c) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
          else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (mem.mem_ready_i) begin
          if (!we_q) ld_d = ld_data_c;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign done_o          = (state_q == S_DONE);
  assign access_err_o    = err_q;
  assign load_data_o     = ld_q;
  assign mem.mem_req_o   = (state_q == S_REQ);
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_wdata_o = wdata_q;
  assign mem.mem_wmask_o = wmask_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: vector table + scoreboard, plus
// hand sequences for back-to-back issue and reset during a request.
module tb_rv32i_lsu;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, sdata;
  logic        stall, done, err;
  logic [31:0] load_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  always #5 clk = ~clk;

  rv32i_lsu_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  rv32i_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .is_load_i    (is_load),
    .is_store_i   (is_store),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .store_data_i (sdata),
    .stall_o      (stall),
    .done_o       (done),
    .load_data_o  (load_data),
    .access_err_o (err),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned_o (misaligned),
`endif
    .mem          (mem_if)
  );

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, sdata, rdata;
    int          dly;
    logic        acc, we;
    logic [31:0] eaddr, ewdata;
    logic [3:0]  emask;
    logic [31:0] eload;
    logic        err, mis;
  } vec_t;

  typedef struct {
    logic [31:0] load;
    logic        err, mis;
    int          cycles, reqs;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                              input int dly, input logic acc, input logic we,
                              input logic [31:0] ea, input logic [31:0] ewd, input logic [3:0] em,
                              input logic [31:0] el, input logic e, input logic mis);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rd;
    v.dly = dly; v.acc = acc; v.we = we; v.eaddr = ea; v.ewdata = ewd;
    v.emask = em; v.eload = el; v.err = e; v.mis = mis;
    return v;
  endfunction

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; sdata = sd;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0; sdata = '0;
  endtask

  task automatic run(input vec_t v, input int idx);
    exp_t        e, got;
    int          cyc, rq;
    logic        stable, stall_ok;
    logic [31:0] a0, wd0;
    logic [3:0]  wm0;
    logic        we0;
    string       tag;
    tag = $sformatf("v%0d", idx);
    e.load = v.eload; e.err = v.err; e.mis = v.mis;
    e.reqs = v.acc ? v.dly + 1 : 0;
    e.cycles = e.reqs;
    @(negedge clk);
    drive(v.ld, v.st, v.f3, v.addr, v.sdata);
    sb.push_back(e);
    #1 chk({tag, "_stall_accept"}, stall, 1);
    @(posedge clk); #1;
    idle_inputs();
    cyc = 0; rq = 0; stable = 1'b1; stall_ok = 1'b1;
    a0 = '0; wd0 = '0; wm0 = '0; we0 = 1'b0;
    while (done !== 1'b1 && cyc < 20) begin
      if (mem_if.mem_req_o === 1'b1) begin
        if (rq == 0) begin
          a0 = mem_if.mem_addr_o; wd0 = mem_if.mem_wdata_o;
          wm0 = mem_if.mem_wmask_o; we0 = mem_if.mem_we_o;
          chk({tag, "_addr"}, a0, v.eaddr);
          chk({tag, "_we"}, we0, v.we);
          chk({tag, "_wmask"}, wm0, v.emask);
          if (v.we) chk({tag, "_wdata"}, wd0, v.ewdata);
        end else if (mem_if.mem_addr_o !== a0 || mem_if.mem_wdata_o !== wd0 ||
                     mem_if.mem_wmask_o !== wm0 || mem_if.mem_we_o !== we0) begin
          stable = 1'b0;
        end
        if (stall !== 1'b1) stall_ok = 1'b0;
        mem_if.mem_ready_i = (rq == v.dly);
        mem_if.mem_rdata_i = v.rdata;
        rq++;
      end
      @(posedge clk); #1;
      mem_if.mem_ready_i = 1'b0;
      cyc++;
    end
    chk({tag, "_done"}, done, 1);
    got = sb.pop_front();
    chk({tag, "_latency"}, 32'(cyc), 32'(got.cycles));
    chk({tag, "_req_cycles"}, 32'(rq), 32'(got.reqs));
    chk({tag, "_load_data"}, load_data, got.load);
    chk({tag, "_access_err"}, err, got.err);
    chk({tag, "_stall_in_done"}, stall, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk({tag, "_misaligned"}, misaligned, got.mis);
`endif
    if (v.acc && v.dly > 0) begin
      chk({tag, "_req_stable"}, stable, 1);
      chk({tag, "_stall_held"}, stall_ok, 1);
    end
    @(posedge clk); #1;
    chk({tag, "_done_single"}, done, 0);
  endtask

  initial begin
    logic bad;
    vecs.push_back(mk(1, 0, F3_W,  32'h100, 0, 32'hDEADBEEF, 0, 1, 0, 32'h100, 0, 4'b0000, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, 0, F3_B,  32'h103, 0, 32'h80FF1234, 0, 1, 0, 32'h100, 0, 4'b0000, 32'hFFFFFF80, 0, 0));
    vecs.push_back(mk(1, 0, F3_BU, 32'h103, 0, 32'h80FF1234, 0, 1, 0, 32'h100, 0, 4'b0000, 32'h00000080, 0, 0));
    vecs.push_back(mk(1, 0, F3_H,  32'h102, 0, 32'h80FF1234, 0, 1, 0, 32'h100, 0, 4'b0000, 32'hFFFF80FF, 0, 0));
    vecs.push_back(mk(1, 0, F3_HU, 32'h100, 0, 32'h80FF1234, 0, 1, 0, 32'h100, 0, 4'b0000, 32'h00001234, 0, 0));
    vecs.push_back(mk(0, 1, F3_H,  32'h102, 32'h0000ABCD, 0, 0, 1, 1, 32'h100, 32'hABCDABCD, 4'b1100, 32'h00001234, 0, 0));
    vecs.push_back(mk(0, 1, F3_B,  32'h101, 32'h00000077, 0, 0, 1, 1, 32'h100, 32'h77777777, 4'b0010, 32'h00001234, 0, 0));
    vecs.push_back(mk(0, 1, F3_W,  32'h204, 32'h12345678, 0, 0, 1, 1, 32'h204, 32'h12345678, 4'b1111, 32'h00001234, 0, 0));
    vecs.push_back(mk(1, 0, F3_W,  32'h300, 0, 32'hCAFEF00D, 3, 1, 0, 32'h300, 0, 4'b0000, 32'hCAFEF00D, 0, 0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b100, 32'h100, 32'h55, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0, 1, 0));
    vecs.push_back(mk(1, 0, F3_H,  32'h100, 0, 32'h00008001, 1, 1, 0, 32'h100, 0, 4'b0000, 32'hFFFF8001, 0, 0));
    vecs.push_back(mk(1, 1, F3_W,  32'h500, 32'h0BADCAFE, 0, 0, 1, 1, 32'h500, 32'h0BADCAFE, 4'b1111, 32'hFFFF8001, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(1, 0, F3_W,  32'h10B, 0, 32'h01020304, 0, 0, 0, 0, 0, 4'b0000, 32'hFFFF8001, 0, 1));
`else
    vecs.push_back(mk(1, 0, F3_W,  32'h10B, 0, 32'h01020304, 0, 1, 0, 32'h108, 0, 4'b0000, 32'h01020304, 0, 0));
`endif
    vecs.push_back(mk(1, 0, F3_B,  32'h102, 0, 32'h00AB0000, 0, 1, 0, 32'h100, 0, 4'b0000, 32'hFFFFFFAB, 0, 0));
    vecs.push_back(mk(1, 0, F3_BU, 32'h102, 0, 32'h00AB0000, 2, 1, 0, 32'h100, 0, 4'b0000, 32'h000000AB, 0, 0));

    rst = 1'b1;
    idle_inputs();
    mem_if.mem_ready_i = 1'b0;
    mem_if.mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_if.mem_req_o, 0);
    chk("rst_mem_we", mem_if.mem_we_o, 0);
    chk("rst_mem_addr", mem_if.mem_addr_o, 0);
    chk("rst_mem_wdata", mem_if.mem_wdata_o, 0);
    chk("rst_mem_wmask", mem_if.mem_wmask_o, 0);
    chk("rst_done", done, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_access_err", err, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

    // Next op presented during DONE is taken on the following IDLE cycle.
    @(negedge clk);
    drive(1, 0, F3_W, 32'h400, 0);
    @(posedge clk); #1;
    idle_inputs();
    mem_if.mem_ready_i = 1'b1;
    mem_if.mem_rdata_i = 32'h00000011;
    @(posedge clk); #1;
    mem_if.mem_ready_i = 1'b0;
    chk("b2b_done1", done, 1);
    drive(0, 1, F3_B, 32'h402, 32'h0000005A);
    #1 chk("b2b_stall_in_done", stall, 0);
    @(posedge clk); #1;
    chk("b2b_stall_idle_accept", stall, 1);
    chk("b2b_no_early_req", mem_if.mem_req_o, 0);
    @(posedge clk); #1;
    idle_inputs();
    chk("b2b_req", mem_if.mem_req_o, 1);
    chk("b2b_we", mem_if.mem_we_o, 1);
    chk("b2b_addr", mem_if.mem_addr_o, 32'h400);
    chk("b2b_wmask", mem_if.mem_wmask_o, 4'b0100);
    chk("b2b_wdata", mem_if.mem_wdata_o, 32'h5A5A5A5A);
    mem_if.mem_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_if.mem_ready_i = 1'b0;
    chk("b2b_done2", done, 1);
    chk("b2b_load_hold", load_data, 32'h00000011);
    @(posedge clk); #1;

    // Reset while a request is outstanding; a late ready must be ignored.
    @(negedge clk);
    drive(1, 0, F3_W, 32'h600, 0);
    @(posedge clk); #1;
    idle_inputs();
    chk("rstreq_req_before", mem_if.mem_req_o, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstreq_req_dropped", mem_if.mem_req_o, 0);
    chk("rstreq_stall", stall, 0);
    chk("rstreq_load_cleared", load_data, 0);
    mem_if.mem_ready_i = 1'b1;
    mem_if.mem_rdata_i = 32'hBAADF00D;
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || mem_if.mem_req_o !== 1'b0) bad = 1'b1;
    end
    mem_if.mem_ready_i = 1'b0;
    chk("rstreq_late_ready_ignored", bad, 0);

    run(vecs[0], 99);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
Name: rv32i_lsu

Overview:
Multi-cycle load/store unit that consumes the execute stage's ALU result as an effective address. It drives a request/ready data-memory port and returns sign- or zero-extended load data for writeback. It sits between execute and writeback, and raises a stall while a memory access is outstanding. It handles byte-lane steering, write masks and load extraction for RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.

Parameters:
ADDR_W, 32, width of effective address and mem_addr_o
DATA_W, 32, data width; only 32 supported

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous active-high reset
req_valid_i  input  1  execute presents a memory op this cycle
is_load_i  input  1  op is a load
is_store_i  input  1  op is a store
funct3_i  input  3  RV32I funct3 (size/sign)
addr_i  input  ADDR_W  effective address (ALU result)
store_data_i  input  32  rs2 value
stall_o  output  1  hold upstream pipeline
done_o  output  1  one-cycle completion pulse
load_data_o  output  32  extended load result, valid with done_o
access_err_o  output  1  unsupported funct3; pulses with done_o
mem_req_o  output  1  memory request
mem_we_o  output  1  1=write
mem_addr_o  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_wdata_o  output  32  lane-replicated store data
mem_wmask_o  output  4  byte write enables
mem_ready_i  input  1  memory accepts (write) / returns rdata (read) this cycle
mem_rdata_i  input  32  read word, valid when mem_ready_i

Behaviour:
- Reset: state IDLE. All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o, done_o, load_data_o, access_err_o, stall_o.
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Accepts when req_valid_i and (is_load_i or is_store_i).
  - On accept, latches addr, store data, funct3 and we (is_store_i wins if both set), then goes to REQ.
  - Unsupported funct3: no memory access; goes to DONE with access_err_o=1 and load_data_o=0.
  - Loads: 000, 001, 010, 100, 101 supported. Stores: 000, 001, 010 supported.
- REQ:
  - mem_req_o=1; addr/we/wdata/wmask held stable until mem_ready_i.
  - On mem_ready_i: a load registers the extracted rdata into load_data_o; goes to DONE.
  - Any number of wait cycles is allowed.
- DONE: done_o=1 for exactly one cycle, then IDLE. load_data_o holds until the next load completes.
- Latency: accept cycle N, mem_req_o in N+1. With ready in N+1, done_o is in N+2.
- stall_o: combinational. Equals (IDLE and accepting) or state==REQ. It is 0 in DONE, so the next op may be presented in the DONE cycle and is accepted in the following IDLE cycle.
- req_valid_i outside IDLE is ignored.
- Store lanes:
  - SB: mask = 1<<addr[1:0]; wdata = {4{byte}}.
  - SH: mask = addr[1] ? 1100 : 0011; wdata = {2{half}}.
  - SW: mask = 1111.
  - Loads drive mask 0000.
- Load extract: shift rdata right by 8*addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Reset mid-REQ: next edge returns to IDLE and drops mem_req_o. A late mem_ready_i is ignored.

Optional Feature:
LSU_MISALIGN_TRAP_EN:
- Defined: on accept, a halfword with addr[0]=1, or a word with addr[1:0]!=0, issues no memory request. The block goes straight to DONE with misaligned_o=1 (an extra 1-bit output, pulsing with done_o).
- Undefined: no misaligned_o port. Low address bits are ignored beyond lane selection: LW/SW use the aligned word; LH/SH use addr[1] only.

Decomposition:
- Shared package rv32i_pkg holds:
  - FSM state encoding (IDLE/REQ/DONE)
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - mask constants
- One natural sub-module, rv32i_lsu_align: purely combinational store-lane replication/mask generation and load extract/extend. Keeps the FSM file under ~200 lines.

Test Plan:
- LW addr 0x100, memory ready on first REQ cycle, rdata 0xDEADBEEF -> mem_req_o one cycle, mem_addr_o 0x100, done_o at N+2, load_data_o 0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF1234 -> load_data_o 0xFFFFFF80. Same with LBU -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SH addr 0x102 data 0x0000ABCD -> mem_we_o=1, wmask 1100, wdata 0xABCDABCD, addr 0x100. SB addr 0x101 data 0x77 -> wmask 0010.
- LW with mem_ready_i delayed 3 cycles -> mem_req_o/addr stable 4 cycles, stall_o high throughout, single done_o.
- rst asserted during REQ -> next cycle mem_req_o=0, state IDLE. Later mem_ready_i produces no done_o.
- funct3=011 load -> no mem_req_o, done_o and access_err_o pulse. With LSU_MISALIGN_TRAP_EN, LW at 0x101 -> misaligned_o pulse, no mem_req_o.
